// File: rtl/seq_checker.sv
// Sequence checker for an upstream 8-bit incrementing counter: HUNT/SYNC/LOCK with flywheel.
// Optional saturating mismatch counter enabled by macro SEQ_CHECKER_ERRCNT_EN.
module seq_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  din,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  expected,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_e;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERR);

  state_e      state_q, state_d;
  logic        locked_q, locked_d;
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  expected_q, expected_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;

  always_comb begin
    state_d     = state_q;
    err_pulse_d = 1'b0;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (enable) begin
      case (state_q)
        HUNT: begin
          expected_d  = din + 8'd1;
          match_cnt_d = 4'd1;
          state_d     = SYNC;
        end
        SYNC: begin
          expected_d = din + 8'd1;
          if (din == expected_q) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d == LOCK_C) begin
              state_d    = LOCK;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 4'd1;
          end
        end
        LOCK: begin
          // flywheel: keep counting from our own prediction, never re-seed from din
          expected_d = expected_q + 8'd1;
          if (din == expected_q) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            miss_cnt_d  = miss_cnt_q + 4'd1;
            if (miss_cnt_d == UNLOCK_C) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      expected_q  <= 8'h00;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= 16'h0000;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue, a negedge monitor pops and compares.
module tb_seq_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        locked, err_pulse;
  logic [7:0]  expected;
  logic [15:0] err_count;

  typedef struct {
    int          tgt;
    logic        l;
    logic        e;
    logic [7:0]  x;
    logic [15:0] c;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  seq_checker #(.LOCK_CNT(4), .UNLOCK_ERR(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .din(din),
    .locked(locked), .err_pulse(err_pulse), .expected(expected), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ec(input int n);
`ifdef SEQ_CHECKER_ERRCNT_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  // one clock edge of stimulus; expected state after that edge goes to the scoreboard
  task automatic s(input logic r, input logic en, input logic [7:0] d,
                   input logic l, input logic e, input logic [7:0] x, input int n, input string name);
    exp_t it;
    @(posedge clk); #1;
    reset = r; enable = en; din = d;
    it.tgt = cyc + 1; it.l = l; it.e = e; it.x = x; it.c = ec(n); it.name = name;
    q.push_back(it);
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].tgt <= cyc) begin
      exp_t it;
      it = q.pop_front();
      n_chk++;
      if (locked !== it.l || err_pulse !== it.e || expected !== it.x || err_count !== it.c) begin
        n_fail++;
        $display("FAIL %s: got locked=%0b err=%0b exp=%02h cnt=%0d, want locked=%0b err=%0b exp=%02h cnt=%0d",
                 it.name, locked, err_pulse, expected, err_count, it.l, it.e, it.x, it.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    s(1, 0, 8'h00, 0, 0, 8'h00, 0, "reset");
    s(0, 0, 8'h00, 0, 0, 8'h00, 0, "hunt_hold");
    // acquire from 00
    s(0, 1, 8'h00, 0, 0, 8'h01, 0, "acq0");
    s(0, 1, 8'h01, 0, 0, 8'h02, 0, "acq1");
    s(0, 1, 8'h02, 0, 0, 8'h03, 0, "acq2");
    s(0, 1, 8'h03, 1, 0, 8'h04, 0, "acq3_lock");
    for (int v = 4; v < 16; v++) s(0, 1, 8'(v), 1, 0, 8'(v + 1), 0, "run");
    // single glitch, then resume
    s(0, 1, 8'h55, 1, 1, 8'h11, 1, "glitch");
    s(0, 1, 8'h11, 1, 0, 8'h12, 1, "resume");
    // enable gated 5 cycles
    for (int i = 0; i < 5; i++) s(0, 0, 8'hAA, 1, 0, 8'h12, 1, "gate_hold");
    s(0, 1, 8'h12, 1, 0, 8'h13, 1, "gate_resume");
    // err_pulse drops on an idle cycle after a miss
    s(0, 1, 8'h00, 1, 1, 8'h14, 2, "miss_a");
    s(0, 0, 8'h00, 1, 0, 8'h14, 2, "pulse_clear");
    s(0, 1, 8'h14, 1, 0, 8'h15, 2, "good_a");
    // three consecutive misses drop lock
    s(0, 1, 8'hAA, 1, 1, 8'h16, 3, "bad1");
    s(0, 1, 8'hAA, 1, 1, 8'h17, 4, "bad2");
    s(0, 1, 8'hAA, 0, 1, 8'h18, 5, "bad3_unlock");
    s(0, 1, 8'h20, 0, 0, 8'h21, 5, "reacq0");
    s(0, 1, 8'h21, 0, 0, 8'h22, 5, "reacq1");
    s(0, 1, 8'h22, 0, 0, 8'h23, 5, "reacq2");
    s(0, 1, 8'h23, 1, 0, 8'h24, 5, "reacq3_lock");
    // non-consecutive misses keep lock
    s(0, 1, 8'h99, 1, 1, 8'h25, 6, "nc_bad1");
    s(0, 1, 8'h99, 1, 1, 8'h26, 7, "nc_bad2");
    s(0, 1, 8'h26, 1, 0, 8'h27, 7, "nc_good");
    s(0, 1, 8'h99, 1, 1, 8'h28, 8, "nc_bad3");
    s(0, 1, 8'h99, 1, 1, 8'h29, 9, "nc_bad4");
    s(0, 1, 8'h29, 1, 0, 8'h2A, 9, "nc_still_locked");
    // reset mid-lock, with enable high (reset wins)
    s(1, 1, 8'h2A, 0, 0, 8'h00, 0, "reset_lock");
    s(0, 1, 8'h50, 0, 0, 8'h51, 0, "r_acq0");
    s(0, 1, 8'h51, 0, 0, 8'h52, 0, "r_acq1");
    s(0, 1, 8'h52, 0, 0, 8'h53, 0, "r_acq2");
    s(0, 1, 8'h77, 0, 0, 8'h78, 0, "sync_miss_reseed");
    s(0, 1, 8'h78, 0, 0, 8'h79, 0, "r_acq1b");
    s(0, 1, 8'h79, 0, 0, 8'h7A, 0, "r_acq2b");
    s(0, 1, 8'h7A, 1, 0, 8'h7B, 0, "r_acq3_lock");
    // wrap through FF -> 00
    s(1, 0, 8'h00, 0, 0, 8'h00, 0, "reset2");
    s(0, 1, 8'hFA, 0, 0, 8'hFB, 0, "w_acq0");
    s(0, 1, 8'hFB, 0, 0, 8'hFC, 0, "w_acq1");
    s(0, 1, 8'hFC, 0, 0, 8'hFD, 0, "w_acq2");
    s(0, 1, 8'hFD, 1, 0, 8'hFE, 0, "w_lock");
    s(0, 1, 8'hFE, 1, 0, 8'hFF, 0, "wrap_fe");
    s(0, 1, 8'hFF, 1, 0, 8'h00, 0, "wrap_ff");
    s(0, 1, 8'h00, 1, 0, 8'h01, 0, "wrap_00");
    s(0, 1, 8'h01, 1, 0, 8'h02, 0, "wrap_01");
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left unconsumed, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
